p2_grms_qsys_pio_in_edge: RTL and testbench

P2_GRMS_QSYS_PIO_IN_EDGE -- requirements
Module: p2_grms_qsys_pio_in_edge

---
 rtl/p2_grms_qsys_pio_in_edge_if.sv | 24 ++
 rtl/p2_grms_qsys_pio_in_edge.sv | 99 +++++++++
 tb/tb_p2_grms_qsys_pio_in_edge.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/p2_grms_qsys_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the edge-capturing parallel input port.
interface p2_grms_qsys_pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/p2_grms_qsys_pio_in_edge.sv
// Parallel input port with synchronizer, edge capture register, interrupt mask
// and level interrupt, exposed as a 4-word Avalon-MM slave.
module p2_grms_qsys_pio_in_edge #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  p2_grms_qsys_pio_in_edge_if.slave    bus,
  input  logic [WIDTH-1:0]             in_port,
  output logic                         irq
);

  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [1:0]       warm_q, warm_d;
  logic             warmDone;
  logic [WIDTH-1:0] riseVec, fallVec, edgeVec, edgeGated;
  logic [WIDTH-1:0] irqMask_q, irqMask_d;
  logic [WIDTH-1:0] edgeCapture_q, edgeCapture_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr;

  // Two flops for metastability, the third holds last cycle's settled value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // The history flop is still filling after reset, so edges are ignored until the counter saturates.
  always_comb begin
    warmDone = (warm_q == 2'd3);
    warm_d   = warmDone ? warm_q : warm_q + 2'd1;
  end

  always_comb begin
    riseVec = s2_q & ~s3_q;
    fallVec = ~s2_q & s3_q;
    case (EDGE_TYPE)
      0:       edgeVec = riseVec;
      1:       edgeVec = fallVec;
      default: edgeVec = riseVec | fallVec;
    endcase
    edgeGated = warmDone ? edgeVec : '0;
  end

  always_comb begin
    wr            = bus.chipselect & ~bus.write_n;
    irqMask_d     = irqMask_q;
    edgeCapture_d = edgeCapture_q;
    if (wr && bus.address == 2'd2)
      irqMask_d = bus.writedata[WIDTH-1:0];
    if (wr && bus.address == 2'd3)
      edgeCapture_d = edgeCapture_q & ~bus.writedata[WIDTH-1:0];
    // Applied after the clear so a coincident new edge is never lost.
    edgeCapture_d = edgeCapture_d | edgeGated;
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d[WIDTH-1:0] = s2_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqMask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgeCapture_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q        <= '0;
      irqMask_q     <= '0;
      edgeCapture_q <= '0;
      readdata_q    <= '0;
    end else begin
      warm_q        <= warm_d;
      irqMask_q     <= irqMask_d;
      edgeCapture_q <= edgeCapture_d;
      readdata_q    <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edgeCapture_q & irqMask_q);

  generate
    if (WIDTH < 32) begin : gUnusedHigh
      logic unusedWritedataHigh;
      assign unusedWritedataHigh = ^bus.writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_p2_grms_qsys_pio_in_edge.sv
// Directed bench: three instances (rising, falling, any edge) share one stimulus stream.
module tb_p2_grms_qsys_pio_in_edge;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] inPort = 8'h00;
  logic       irq0, irq1, irq2;
  int         checks = 0;
  int         errors = 0;

  p2_grms_qsys_pio_in_edge_if bus0 ();
  p2_grms_qsys_pio_in_edge_if bus1 ();
  p2_grms_qsys_pio_in_edge_if bus2 ();

  p2_grms_qsys_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0)) dutRise (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(inPort), .irq(irq0));
  p2_grms_qsys_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1)) dutFall (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(inPort), .irq(irq1));
  p2_grms_qsys_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2)) dutAny (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(inPort), .irq(irq2));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] value);
    inPort = value;
  endtask

  task automatic setBus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = wd;
    bus1.address = a; bus1.chipselect = cs; bus1.write_n = wn; bus1.writedata = wd;
    bus2.address = a; bus2.chipselect = cs; bus2.write_n = wn; bus2.writedata = wd;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    setBus(a, 1'b1, 1'b0, d);
    @(negedge clk);
    setBus(a, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic readReg(input logic [1:0] a);
    setBus(a, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    setBus(2'd0, 1'b0, 1'b1, 32'h0);
    applyStimulus(8'hFF);
    #1;
    checkOutput("reset_readdata_t0", bus0.readdata, 32'h0);
    checkOutput("reset_irq_t0", {31'b0, irq2}, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("reset_readdata_clocked", bus2.readdata, 32'h0);
    checkOutput("reset_irq_clocked", {31'b0, irq0}, 32'h0);

    // All-ones input held through reset release must never register as an edge
    reset_n = 1'b1;
    busWrite(2'd2, 32'hFF);
    setBus(2'd3, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("warmup_capture_any", bus2.readdata, 32'h0);
      checkOutput("warmup_irq_any", {31'b0, irq2}, 32'h0);
      checkOutput("warmup_irq_rise", {31'b0, irq0}, 32'h0);
    end
    readReg(2'd0);
    checkOutput("warmup_addr0", bus0.readdata, 32'h000000FF);

    // Rising edge on bit 0 with matching mask
    applyStimulus(8'h00);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    busWrite(2'd2, 32'h1);
    readReg(2'd0);
    applyStimulus(8'h01);
    @(negedge clk);
    checkOutput("rise0_irq_n", {31'b0, irq0}, 32'h0);
    @(negedge clk);
    checkOutput("rise0_irq_n1", {31'b0, irq0}, 32'h0);
    checkOutput("rise0_addr0_n1", bus0.readdata, 32'h0);
    @(negedge clk);
    checkOutput("rise0_irq_n2", {31'b0, irq0}, 32'h1);
    checkOutput("rise0_irq_any_n2", {31'b0, irq2}, 32'h1);
    checkOutput("rise0_irq_fall_n2", {31'b0, irq1}, 32'h0);
    checkOutput("rise0_addr0_n2", bus0.readdata, 32'h1);
    readReg(2'd3);
    checkOutput("rise0_cap_rise", bus0.readdata, 32'h01);
    checkOutput("rise0_cap_fall", bus1.readdata, 32'h00);
    checkOutput("rise0_cap_any", bus2.readdata, 32'h01);
    busWrite(2'd3, 32'h1);
    checkOutput("rise0_irq_cleared", {31'b0, irq0}, 32'h0);
    checkOutput("rise0_irq_any_cleared", {31'b0, irq2}, 32'h0);

    // Falling edge on bit 3 is seen only by falling/any instances
    applyStimulus(8'h09);
    repeat (3) @(negedge clk);
    readReg(2'd3);
    checkOutput("rise3_cap_rise", bus0.readdata, 32'h08);
    checkOutput("rise3_cap_any", bus2.readdata, 32'h08);
    busWrite(2'd3, 32'hFF);
    applyStimulus(8'h01);
    repeat (3) @(negedge clk);
    readReg(2'd3);
    checkOutput("fall3_cap_rise", bus0.readdata, 32'h00);
    checkOutput("fall3_cap_fall", bus1.readdata, 32'h08);
    checkOutput("fall3_cap_any", bus2.readdata, 32'h08);

    // Clear-all coinciding with a new rise on bit 5
    busWrite(2'd3, 32'hFF);
    applyStimulus(8'h0F);
    repeat (3) @(negedge clk);
    readReg(2'd3);
    checkOutput("multi_cap_rise", bus0.readdata, 32'h0E);
    checkOutput("multi_cap_fall", bus1.readdata, 32'h00);
    applyStimulus(8'h2F);
    @(negedge clk);
    @(negedge clk);
    busWrite(2'd3, 32'hFF);
    readReg(2'd3);
    checkOutput("setwins_cap_rise", bus0.readdata, 32'h20);
    checkOutput("setwins_cap_any", bus2.readdata, 32'h20);
    checkOutput("setwins_cap_fall", bus1.readdata, 32'h00);
    checkOutput("setwins_irq_unmasked", {31'b0, irq0}, 32'h0);

    // Masking, then a mid-operation reset pulse
    busWrite(2'd2, 32'h0);
    busWrite(2'd3, 32'hFF);
    applyStimulus(8'h3F);
    repeat (3) @(negedge clk);
    readReg(2'd3);
    checkOutput("mask_cap_rise", bus0.readdata, 32'h10);
    checkOutput("mask_irq_masked", {31'b0, irq0}, 32'h0);
    busWrite(2'd2, 32'h10);
    checkOutput("mask_irq_enabled", {31'b0, irq0}, 32'h1);
    checkOutput("mask_irq_any_enabled", {31'b0, irq2}, 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("pulse_irq_rise", {31'b0, irq0}, 32'h0);
    checkOutput("pulse_irq_any", {31'b0, irq2}, 32'h0);
    checkOutput("pulse_readdata", bus0.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    readReg(2'd2);
    checkOutput("pulse_mask_read", bus0.readdata, 32'h0);
    checkOutput("pulse_irq_after", {31'b0, irq0}, 32'h0);

    // Ignored writes, read mux and one-cycle latency
    repeat (3) @(negedge clk);
    busWrite(2'd0, 32'hA5);
    busWrite(2'd1, 32'h5A);
    readReg(2'd0);
    checkOutput("map_addr0", bus0.readdata, 32'h3F);
    setBus(2'd1, 1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("map_latency_hold", bus0.readdata, 32'h3F);
    @(negedge clk);
    checkOutput("map_addr1", bus0.readdata, 32'h0);
    busWrite(2'd2, 32'hFFFFFF33);
    readReg(2'd2);
    checkOutput("map_mask_width", bus0.readdata, 32'h33);
    readReg(2'd3);
    checkOutput("map_no_capture_after_reset", bus2.readdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
